// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with frame debounce and a press/release event FIFO.
// The CPU reads status, the FIFO head, control and the stable key map over the peripheral bus.
module keypad_scan_fifo #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [7:0]      addrIn,
    input  logic [7:0]      addrOut,
    input  logic [3:0]      sizeDecode,
    input  logic [31:0]     dataIn,
    output logic [31:0]     dataOut,
    input  logic [COLS-1:0] COL,
    output logic [ROWS-1:0] ROW,
    output logic            irq
);

    localparam int unsigned NKEYS = ROWS * COLS;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DW    = $clog2(SCAN_DIV);
    localparam int unsigned KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int unsigned CW    = $clog2(DEBOUNCE + 1);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned NW    = PW + 1;

    typedef enum logic [1:0] {StScan, StCheck, StEmit} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [NKEYS-1:0]  frame_q, frame_d;
    logic [NKEYS-1:0]  cand_q, cand_d;
    logic [NKEYS-1:0]  stable_q, stable_d;
    logic [CW-1:0]     debcnt_q, debcnt_d;
    logic [KW-1:0]     key_q, key_d;
    logic [2:0]        ctrl_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]     count_q;
    logic              ovf_q;
    logic [ROWS-1:0]   row_drv_q, row_drv_d;
    logic              irq_q;
    logic [31:0]       dout_q, rdata;
    logic [8:0]        mem [FIFO_DEPTH];

    logic              push, push_ok, pop, full, empty;
    logic [8:0]        push_data;
    logic [CW-1:0]     cnt_nxt;
    logic [KW-1:0]     frame_base;
    logic              ctrl_we, ovf_clr;
    logic              unused_bits;

    assign unused_bits = ^dataIn[31:3];

    assign full    = (count_q == NW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign ctrl_we = (addrIn == 8'd2) && sizeDecode[0];
    assign ovf_clr = (addrIn == 8'd0) && sizeDecode[0] && dataIn[2];
    assign pop     = (addrIn == 8'd3) && (sizeDecode != 4'd0) && !empty;
    assign push_ok = push && !full;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        dwell_d    = dwell_q;
        frame_d    = frame_q;
        cand_d     = cand_q;
        stable_d   = stable_q;
        debcnt_d   = debcnt_q;
        key_d      = key_q;
        push       = 1'b0;
        push_data  = '0;
        cnt_nxt    = debcnt_q;
        frame_base = KW'(row_q * COLS);
        if (!ctrl_q[0]) begin
            state_d  = StScan;
            row_d    = '0;
            dwell_d  = '0;
            debcnt_d = '0;
        end else begin
            unique case (state_q)
                StScan: begin
                    if (dwell_q == DW'(SCAN_DIV - 1)) begin
                        dwell_d = '0;
                        frame_d[frame_base +: COLS] = ~COL;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = StCheck;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                StCheck: begin
                    if (frame_q == cand_q) begin
                        cnt_nxt = (debcnt_q == CW'(DEBOUNCE)) ? debcnt_q : debcnt_q + 1'b1;
                    end else begin
                        cand_d  = frame_q;
                        cnt_nxt = CW'(1);
                    end
                    debcnt_d = cnt_nxt;
                    key_d    = '0;
                    if (cnt_nxt == CW'(DEBOUNCE) && cand_d != stable_q) begin
                        state_d = StEmit;
                    end else begin
                        state_d = StScan;
                    end
                end
                StEmit: begin
                    push_data = {cand_q[key_q], 8'(key_q)};
                    if (cand_q[key_q] != stable_q[key_q]) begin
                        stable_d[key_q] = cand_q[key_q];
                        push            = cand_q[key_q] | ctrl_q[2];
                    end
                    if (key_q == KW'(NKEYS - 1)) begin
                        key_d   = '0;
                        state_d = StScan;
                    end else begin
                        key_d = key_q + 1'b1;
                    end
                end
                default: state_d = StScan;
            endcase
        end
        // Row drive is registered from the next state so it lines up with the dwell count.
        row_drv_d = (ctrl_q[0] && state_d == StScan) ? ~(ROWS'(1) << row_d) : '1;
    end

    always_comb begin
        rdata = '0;
        case (addrOut)
            8'd0: rdata = {24'd0, 4'(count_q), 1'b0, ovf_q, full, !empty};
            8'd1: rdata = empty ? 32'hFFFF_FFFF : {1'b1, 22'd0, mem[rd_ptr_q]};
            8'd2: rdata = {29'd0, ctrl_q};
            8'd4: rdata = 32'(stable_q);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StScan;
            row_q     <= '0;
            dwell_q   <= '0;
            frame_q   <= '0;
            cand_q    <= '0;
            stable_q  <= '0;
            debcnt_q  <= '0;
            key_q     <= '0;
            ctrl_q    <= 3'b001;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            row_drv_q <= '1;
            irq_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            dwell_q   <= dwell_d;
            frame_q   <= frame_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            debcnt_q  <= debcnt_d;
            key_q     <= key_d;
            row_drv_q <= row_drv_d;
            dout_q    <= rdata;
            irq_q     <= ctrl_q[1] & !empty;
            if (ctrl_we) begin
                ctrl_q <= dataIn[2:0];
            end
            // A new overflow in the same cycle as a clear stays visible.
            if (push && full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign ROW     = row_drv_q;
    assign irq     = irq_q;
    assign dataOut = dout_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: a matrix model drives COL from ROW and a
// scoreboard checks every register read against hand-computed values.
module tb_keypad_scan_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  addrIn, addrOut;
    logic [3:0]  sizeDecode;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [3:0]  COL, ROW;
    logic        irq;
    logic [15:0] keys;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;
    logic [31:0] mon_exp;
    string       mon_name;

    keypad_scan_fifo #(
        .ROWS       (4),
        .COLS       (4),
        .SCAN_DIV   (4),
        .DEBOUNCE   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .addrIn     (addrIn),
        .addrOut    (addrOut),
        .sizeDecode (sizeDecode),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .COL        (COL),
        .ROW        (ROW),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Closed key pulls its column low while its row is driven.
    always_comb begin
        COL = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!ROW[r]) COL = COL & ~keys[r*4 +: 4];
        end
    end

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: dataOut=%h with empty scoreboard", dataOut);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (dataOut !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: dataOut=%h expected %h", mon_name, dataOut, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        @(negedge clk);
        addrOut = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addrIn     = a;
        dataIn     = d;
        sizeDecode = be;
        @(negedge clk);
        sizeDecode = 4'd0;
    endtask

    // Returns at the negedge inside the CHECK cycle (row 3 drive just dropped).
    task automatic wait_check();
        logic [3:0] prev;
        bit         seen;
        prev = ROW;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (prev == 4'b0111 && ROW == 4'b1111) seen = 1'b1;
            prev = ROW;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_check: timeout, ROW=%b", ROW);
        end
    endtask

    task automatic wait_row(input logic [3:0] v, input bit eq);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if ((ROW == v) == eq) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_row: timeout, ROW=%b", ROW);
        end
    endtask

    // Change one key at a frame boundary and let debounce plus emit complete.
    task automatic set_key(input int k, input bit v);
        wait_check();
        keys[k] = v;
        wait_check();
        wait_check();
        wait_check();
    endtask

    initial begin
        rstn       = 1'b0;
        addrIn     = 8'd0;
        addrOut    = 8'd0;
        sizeDecode = 4'd0;
        dataIn     = 32'd0;
        keys       = 16'd0;

        // 1. reset and idle scanning
        repeat (3) @(negedge clk);
        chk("reset_row", 32'(ROW), 32'hF);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_dout", dataOut, 32'h0);
        rstn = 1'b1;
        wait_check();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] one_cold;
            one_cold = ~(4'b0001 << (i / 4));
            @(negedge clk);
            chk($sformatf("scan_row_%0d", i), 32'(ROW), 32'(one_cold));
        end
        @(negedge clk);
        chk("check_row_idle", 32'(ROW), 32'hF);
        rd(8'd1, 32'hFFFF_FFFF, "t1_data_empty");
        rd(8'd0, 32'h0, "t1_status");
        rd(8'd2, 32'h1, "t1_ctrl");
        rd(8'd4, 32'h0, "t1_raw");
        rd(8'd5, 32'h0, "t1_unmapped");
        chk("t1_irq", 32'(irq), 32'h0);

        // 2. key 6 (row 1, col 2) held for several frames
        set_key(6, 1'b1);
        rd(8'd1, 32'h8000_0106, "t2_data");
        rd(8'd0, 32'h11, "t2_status");
        rd(8'd4, 32'h40, "t2_raw");
        wr(8'd3, 32'd0, 4'b0001);
        rd(8'd0, 32'h0, "t2_status_pop");
        rd(8'd1, 32'hFFFF_FFFF, "t2_data_pop");
        set_key(6, 1'b0);
        rd(8'd4, 32'h0, "t2_raw_release");
        rd(8'd0, 32'h0, "t2_release_unreported");

        // 3. key 6 seen in a single frame only
        wait_check();
        wait_row(4'b1101, 1'b1);
        keys[6] = 1'b1;
        wait_row(4'b1101, 1'b0);
        keys[6] = 1'b0;
        wait_check();
        wait_check();
        wait_check();
        rd(8'd0, 32'h0, "t3_status");
        rd(8'd4, 32'h0, "t3_raw");

        // 4. releases reported, irq follows FIFO occupancy
        wr(8'd2, 32'h7, 4'b0001);
        rd(8'd2, 32'h7, "t4_ctrl");
        wr(8'd2, 32'h0, 4'b0010);
        rd(8'd2, 32'h7, "t4_ctrl_byte1_ignored");
        set_key(0, 1'b1);
        chk("t4_irq_press", 32'(irq), 32'h1);
        set_key(0, 1'b0);
        rd(8'd0, 32'h21, "t4_status");
        rd(8'd1, 32'h8000_0100, "t4_data_press");
        wr(8'd3, 32'd0, 4'b1000);
        rd(8'd1, 32'h8000_0000, "t4_data_release");
        chk("t4_irq_one_left", 32'(irq), 32'h1);
        wr(8'd3, 32'd0, 4'b0001);
        chk("t4_irq_lag", 32'(irq), 32'h1);
        @(negedge clk);
        chk("t4_irq_clear", 32'(irq), 32'h0);

        // 5. overflow with releases unreported
        wr(8'd2, 32'h3, 4'b0001);
        set_key(1, 1'b1);  set_key(1, 1'b0);
        set_key(5, 1'b1);  set_key(5, 1'b0);
        set_key(10, 1'b1); set_key(10, 1'b0);
        set_key(15, 1'b1); set_key(15, 1'b0);
        set_key(3, 1'b1);  set_key(3, 1'b0);
        rd(8'd0, 32'h47, "t5_status_full_ovf");
        wr(8'd0, 32'h4, 4'b0001);
        rd(8'd0, 32'h43, "t5_status_ovf_cleared");
        rd(8'd1, 32'h8000_0101, "t5_fifo0"); wr(8'd3, 32'd0, 4'b0001);
        rd(8'd1, 32'h8000_0105, "t5_fifo1"); wr(8'd3, 32'd0, 4'b0001);
        rd(8'd1, 32'h8000_010A, "t5_fifo2"); wr(8'd3, 32'd0, 4'b0001);
        rd(8'd1, 32'h8000_010F, "t5_fifo3"); wr(8'd3, 32'd0, 4'b0001);
        rd(8'd0, 32'h0, "t5_status_drained");
        wr(8'd3, 32'd0, 4'b0001);
        rd(8'd0, 32'h0, "t5_pop_empty");

        // 6. pop coincident with an emit push at count 2, then reset mid-emit
        set_key(2, 1'b1); set_key(2, 1'b0);
        set_key(4, 1'b1); set_key(4, 1'b0);
        rd(8'd0, 32'h21, "t6_status_two");
        wait_check();
        keys[9] = 1'b1;
        wait_check();
        wait_check();
        repeat (10) @(posedge clk);
        #1;
        addrIn     = 8'd3;
        sizeDecode = 4'b0001;
        @(posedge clk);
        #1;
        sizeDecode = 4'd0;
        wait_check();
        rd(8'd0, 32'h21, "t6_status_push_pop");
        rd(8'd1, 32'h8000_0104, "t6_head");
        wr(8'd3, 32'd0, 4'b0001);
        rd(8'd1, 32'h8000_0109, "t6_tail");
        wait_check();
        keys[9]  = 1'b0;
        keys[12] = 1'b1;
        wait_check();
        wait_check();
        chk("t6_irq_before_reset", 32'(irq), 32'h1);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_reset_row", 32'(ROW), 32'hF);
        chk("t6_reset_irq", 32'(irq), 32'h0);
        chk("t6_reset_dout", dataOut, 32'h0);
        keys = 16'd0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rd(8'd0, 32'h0, "t6_status_after_reset");
        rd(8'd1, 32'hFFFF_FFFF, "t6_data_after_reset");
        rd(8'd4, 32'h0, "t6_raw_after_reset");
        rd(8'd2, 32'h1, "t6_ctrl_after_reset");

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d reads never observed", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
